// File: rtl/key_extractor_pkg.sv
// Key extractor shared definitions: PHV container layout,
// key layout and extraction-table entry format.
package key_extractor_pkg;

    localparam int PHV_W    = 1124;
    localparam int KEY_W    = 197;

    // 48b containers, MSB-first from the top of the PHV
    localparam int N48      = 8;
    localparam int W48      = 48;
    localparam int C48_MSB  = 1123;

    // 32b containers
    localparam int N32      = 8;
    localparam int W32      = 32;
    localparam int C32_MSB  = 739;

    // 16b containers
    localparam int N16      = 8;
    localparam int W16      = 16;
    localparam int C16_MSB  = 483;

    // 20b containers
    localparam int N20      = 5;
    localparam int W20      = 20;
    localparam int C20_MSB  = 355;

    // metadata: table index and flags
    localparam int VID_MSB  = 255;
    localparam int VID_W    = 4;
    localparam int FLAG_LSB = 0;
    localparam int FLAG_W   = 5;

    // extraction table
    localparam int TBL_DEPTH = 16;
    localparam int TBL_AW    = 4;
    localparam int IDX_W     = 3;
    localparam int ENTRY_W   = 23;

    // entry field MSB positions
    localparam int E_IDX48A_MSB = 22;
    localparam int E_IDX48B_MSB = 19;
    localparam int E_IDX32A_MSB = 16;
    localparam int E_IDX32B_MSB = 13;
    localparam int E_IDX16A_MSB = 10;
    localparam int E_IDX16B_MSB = 7;
    localparam int E_MASK_MSB   = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx48a;
        logic [IDX_W-1:0]  idx48b;
        logic [IDX_W-1:0]  idx32a;
        logic [IDX_W-1:0]  idx32b;
        logic [IDX_W-1:0]  idx16a;
        logic [IDX_W-1:0]  idx16b;
        logic [FLAG_W-1:0] flag_mask;
    } cfg_entry_t;

endpackage

// File: rtl/key_extract_cfg_ram.sv
// 16 x 23b extraction table: one write port, one registered
// read port. Ports: clk, rst, we/waddr/wdata, re/raddr, rdata.
module key_extract_cfg_ram
    import key_extractor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [TBL_AW-1:0] waddr,
    input  cfg_entry_t        wdata,
    input  logic              re,
    input  logic [TBL_AW-1:0] raddr,
    output cfg_entry_t        rdata
);

    cfg_entry_t mem [TBL_DEPTH];

    // Read-before-write: a read colliding with a write to the
    // same entry returns the old contents. rdata only moves on
    // re, so a captured entry is immune to later writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/key_extractor.sv
// Two-stage key extractor: S1 captures PHV + table entry, S2
// registers the muxed key. Ports: clk, rst, phv_in/valid/ready,
// extract_key/key_valid/key_ready, phv_out, cfg_din/addr/en.
module key_extractor
    import key_extractor_pkg::*;
#(
    parameter int STAGE   = 0,
    parameter int PHV_LEN = 1124,
    parameter int KEY_LEN = 197
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid,
    output logic               phv_ready,
    output logic [KEY_LEN-1:0] extract_key,
    output logic               key_valid,
    input  logic               key_ready,
    output logic [PHV_LEN-1:0] phv_out,
    input  logic [22:0]        cfg_din,
    input  logic [3:0]         cfg_addr,
    input  logic               cfg_en
);

    // container layout is fixed by the package
    if (PHV_LEN != PHV_W || KEY_LEN != KEY_W || STAGE < 0)
    begin : g_bad_cfg
        $error("key_extractor: unsupported parameters");
    end

    logic               stall;
    logic               accept;
    logic               s1_valid;
    logic [PHV_LEN-1:0] s1_phv;
    cfg_entry_t         s1_entry;
    logic [KEY_LEN-1:0] key_d;

    logic [W48-1:0]     c48 [N48];
    logic [W32-1:0]     c32 [N32];
    logic [W16-1:0]     c16 [N16];
    logic [FLAG_W-1:0]  flags;

    // global stall: the whole pipe freezes behind S2
    assign stall     = key_valid & ~key_ready;
    assign phv_ready = ~stall;
    assign accept    = phv_valid & phv_ready;

    key_extract_cfg_ram u_cfg_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_en),
        .waddr (cfg_addr),
        .wdata (cfg_entry_t'(cfg_din)),
        .re    (accept),
        .raddr (phv_in[VID_MSB -: VID_W]),
        .rdata (s1_entry)
    );

    for (genvar i = 0; i < N48; i++) begin : g_c48
        assign c48[i] = s1_phv[C48_MSB - W48*i -: W48];
    end

    for (genvar i = 0; i < N32; i++) begin : g_c32
        assign c32[i] = s1_phv[C32_MSB - W32*i -: W32];
    end

    for (genvar i = 0; i < N16; i++) begin : g_c16
        assign c16[i] = s1_phv[C16_MSB - W16*i -: W16];
    end

    assign flags = s1_phv[FLAG_LSB +: FLAG_W];

    assign key_d = {
        c48[s1_entry.idx48a],
        c48[s1_entry.idx48b],
        c32[s1_entry.idx32a],
        c32[s1_entry.idx32b],
        c16[s1_entry.idx16a],
        c16[s1_entry.idx16b],
        flags & s1_entry.flag_mask
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_phv      <= '0;
            key_valid   <= 1'b0;
            extract_key <= '0;
            phv_out     <= '0;
        end else if (!stall) begin
            s1_valid  <= accept;
            key_valid <= s1_valid;
            if (accept) begin
                s1_phv <= phv_in;
            end
            if (s1_valid) begin
                extract_key <= key_d;
                phv_out     <= s1_phv;
            end
        end
    end

endmodule

// File: tb/tb_key_extractor.sv
// Directed bench for key_extractor: reset, extraction, mask,
// throughput, backpressure, config collision, mid-flight reset.
module tb_key_extractor;

    logic          clk = 1'b0;
    logic          rst;
    logic [1123:0] phv_in;
    logic          phv_valid;
    logic          phv_ready;
    logic [196:0]  extract_key;
    logic          key_valid;
    logic          key_ready;
    logic [1123:0] phv_out;
    logic [22:0]   cfg_din;
    logic [3:0]    cfg_addr;
    logic          cfg_en;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [22:0] tbl [16];

    always #5 clk = ~clk;

    key_extractor #(
        .STAGE   (0),
        .PHV_LEN (1124),
        .KEY_LEN (197)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phv_in      (phv_in),
        .phv_valid   (phv_valid),
        .phv_ready   (phv_ready),
        .extract_key (extract_key),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .phv_out     (phv_out),
        .cfg_din     (cfg_din),
        .cfg_addr    (cfg_addr),
        .cfg_en      (cfg_en)
    );

    function automatic logic [1123:0] mk_phv(
        input int seed, input logic [3:0] vid,
        input logic [4:0] flags);
        logic [1123:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p[1123-48*i -: 48] = {8'(seed), 8'(i), 32'h4848_0000};
            p[739-32*i -: 32]  = {8'(seed), 8'(i), 16'h3232};
            p[483-16*i -: 16]  = {8'(seed), 8'(i)};
        end
        p[355 -: 20]  = 20'(seed);
        p[200 -: 32]  = 32'(seed * 7 + 1);
        p[255:252]    = vid;
        p[4:0]        = flags;
        return p;
    endfunction

    function automatic logic [196:0] model_key(
        input logic [22:0] e, input logic [1123:0] p);
        logic [2:0] a, b, c, d, f, g;
        logic [4:0] m;
        int ia, ib, ic, id, i_f, ig;
        {a, b, c, d, f, g, m} = e;
        ia = int'(a); ib = int'(b); ic = int'(c);
        id = int'(d); i_f = int'(f); ig = int'(g);
        return {p[1123-48*ia -: 48], p[1123-48*ib -: 48],
                p[739-32*ic -: 32], p[739-32*id -: 32],
                p[483-16*i_f -: 16], p[483-16*ig -: 16],
                p[4:0] & m};
    endfunction

    task automatic cfg_write(input logic [3:0] a,
                             input logic [22:0] d);
        @(negedge clk);
        cfg_en   = 1'b1;
        cfg_addr = a;
        cfg_din  = d;
        @(negedge clk);
        cfg_en   = 1'b0;
        tbl[a]   = d;
    endtask

    task automatic test_reset();
        logic [1123:0] p;
        rst       = 1'b1;
        phv_valid = 1'b0;
        phv_in    = '0;
        key_ready = 1'b1;
        cfg_en    = 1'b1;
        cfg_addr  = 4'd3;
        cfg_din   = 23'h7F_FFFF;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_key_valid got %b exp 0", key_valid);
        end
        n_cmp++;
        if (extract_key !== '0) begin
            n_fail++;
            $display("FAIL rst_key got %h exp 0", extract_key);
        end
        n_cmp++;
        if (phv_out !== '0) begin
            n_fail++;
            $display("FAIL rst_phv_out got %h exp 0",
                     phv_out[63:0]);
        end
        rst    = 1'b0;
        cfg_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (phv_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_phv_ready got %b exp 1", phv_ready);
        end
        // cfg write during reset must not have landed
        p         = mk_phv(9, 4'd3, 5'h1F);
        phv_in    = p;
        phv_valid = 1'b1;
        @(negedge clk);
        phv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b1 ||
            extract_key !== model_key(23'h0, p)) begin
            n_fail++;
            $display("FAIL rst_cfg_ignored got %b/%h exp 1/%h",
                     key_valid, extract_key, model_key(23'h0, p));
        end
    endtask

    task automatic test_basic();
        logic [1123:0] p;
        cfg_write(4'd3, {3'd1, 3'd2, 3'd0, 3'd7,
                         3'd4, 3'd5, 5'h1F});
        p = mk_phv(1, 4'd3, 5'h15);
        p[1123-48 -: 48] = 48'hAAAA_0000_0001;
        p[1123-96 -: 48] = 48'hBBBB_0000_0002;
        phv_in    = p;
        phv_valid = 1'b1;
        @(negedge clk);
        phv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid got %b exp 1", key_valid);
        end
        n_cmp++;
        if (extract_key[196:149] !== 48'hAAAA00000001) begin
            n_fail++;
            $display("FAIL basic_f48a got %h exp aaaa00000001",
                     extract_key[196:149]);
        end
        n_cmp++;
        if (extract_key[148:101] !== 48'hBBBB00000002) begin
            n_fail++;
            $display("FAIL basic_f48b got %h exp bbbb00000002",
                     extract_key[148:101]);
        end
        // c32[0], c32[7], c16[4], c16[5] of seed 1
        n_cmp++;
        if (extract_key[100:5] !== {32'h0100_3232, 32'h0107_3232,
                                    16'h0104, 16'h0105}) begin
            n_fail++;
            $display("FAIL basic_f32_16 got %h exp %h",
                     extract_key[100:5],
                     {32'h0100_3232, 32'h0107_3232,
                      16'h0104, 16'h0105});
        end
        n_cmp++;
        if (extract_key[4:0] !== 5'h15) begin
            n_fail++;
            $display("FAIL basic_flags got %h exp 15",
                     extract_key[4:0]);
        end
        n_cmp++;
        if (phv_out !== p) begin
            n_fail++;
            $display("FAIL basic_phv_out got %h exp %h",
                     phv_out[1123:1060], p[1123:1060]);
        end
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drop got %b exp 0", key_valid);
        end
    endtask

    task automatic test_flag_mask();
        logic [1123:0] p;
        cfg_write(4'd3, {3'd1, 3'd2, 3'd0, 3'd7,
                         3'd4, 3'd5, 5'h03});
        p = mk_phv(1, 4'd3, 5'h15);
        phv_in    = p;
        phv_valid = 1'b1;
        @(negedge clk);
        phv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b1 || extract_key[4:0] !== 5'h01) begin
            n_fail++;
            $display("FAIL mask got %b/%h exp 1/01",
                     key_valid, extract_key[4:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [196:0] exp_k [8];
        logic [1123:0] p;
        logic [3:0] v;
        cfg_write(4'd6, {3'd7, 3'd6, 3'd5, 3'd4,
                         3'd3, 3'd2, 5'h0C});
        key_ready = 1'b1;
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc >= 2 && cyc < 10) begin
                n_cmp++;
                if (key_valid !== 1'b1 ||
                    extract_key !== exp_k[cyc-2]) begin
                    n_fail++;
                    $display("FAIL b2b_key%0d got %b/%h exp 1/%h",
                             cyc - 2, key_valid, extract_key,
                             exp_k[cyc-2]);
                end
            end
            if (cyc == 10) begin
                n_cmp++;
                if (key_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_tail got %b exp 0",
                             key_valid);
                end
            end
            if (cyc < 8) begin
                v = cyc[0] ? 4'd6 : 4'd3;
                p = mk_phv(20 + cyc, v, 5'(cyc * 3 + 1));
                exp_k[cyc] = model_key(tbl[v], p);
                phv_in    = p;
                phv_valid = 1'b1;
            end else begin
                phv_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [196:0] expq [$];
        logic [196:0] prev_key;
        logic prev_stall;
        logic xfer;
        int sent;
        int got;
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        prev_key   = '0;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (extract_key !== prev_key) begin
                    n_fail++;
                    $display("FAIL bp_hold got %h exp %h",
                             extract_key, prev_key);
                end
            end
            key_ready = !(cyc >= 2 && cyc <= 4);
            if (sent < 5) begin
                phv_in    = mk_phv(40 + sent, 4'd3, 5'(sent));
                phv_valid = 1'b1;
            end else begin
                phv_valid = 1'b0;
            end
            #1;
            if (key_valid && !key_ready) begin
                n_cmp++;
                if (phv_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready got %b exp 0",
                             phv_ready);
                end
            end
            xfer = key_valid && key_ready;
            if (xfer) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra got %h exp none",
                             extract_key);
                end else begin
                    if (extract_key !== expq[0]) begin
                        n_fail++;
                        $display("FAIL bp_key%0d got %h exp %h",
                                 got, extract_key, expq[0]);
                    end
                    void'(expq.pop_front());
                end
                got++;
            end
            if (phv_valid && phv_ready) begin
                expq.push_back(model_key(tbl[3], phv_in));
                sent++;
            end
            prev_stall = key_valid && !key_ready;
            prev_key   = extract_key;
        end
        n_cmp++;
        if (got != 5 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count got %0d/%0d exp 5/0",
                     got, expq.size());
        end
        key_ready = 1'b1;
        phv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_dup got %b exp 0", key_valid);
        end
    endtask

    task automatic test_cfg_collision();
        logic [22:0] ea;
        logic [22:0] eb;
        logic [1123:0] p1;
        logic [1123:0] p2;
        ea = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 5'h1F};
        eb = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 5'h00};
        cfg_write(4'd5, ea);
        p1 = mk_phv(60, 4'd5, 5'h1B);
        p2 = mk_phv(61, 4'd5, 5'h1B);
        cfg_en    = 1'b1;
        cfg_addr  = 4'd5;
        cfg_din   = eb;
        phv_in    = p1;
        phv_valid = 1'b1;
        @(negedge clk);
        cfg_en    = 1'b0;
        tbl[5]    = eb;
        phv_in    = p2;
        @(negedge clk);
        phv_valid = 1'b0;
        n_cmp++;
        if (key_valid !== 1'b1 ||
            extract_key !== model_key(ea, p1)) begin
            n_fail++;
            $display("FAIL coll_old got %b/%h exp 1/%h",
                     key_valid, extract_key, model_key(ea, p1));
        end
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b1 ||
            extract_key !== model_key(eb, p2)) begin
            n_fail++;
            $display("FAIL coll_new got %b/%h exp 1/%h",
                     key_valid, extract_key, model_key(eb, p2));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        logic [1123:0] p;
        int stale;
        phv_in    = mk_phv(70, 4'd3, 5'h07);
        phv_valid = 1'b1;
        @(negedge clk);
        phv_in    = mk_phv(71, 4'd3, 5'h07);
        @(negedge clk);
        phv_valid = 1'b0;
        n_cmp++;
        if (key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_inflight got %b exp 1", key_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0 || extract_key !== '0 ||
            phv_out !== '0) begin
            n_fail++;
            $display("FAIL mid_clear got %b/%h exp 0/0",
                     key_valid, extract_key);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        @(negedge clk);
        n_cmp++;
        if (phv_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready got %b exp 1", phv_ready);
        end
        stale = 0;
        repeat (3) begin
            @(negedge clk);
            if (key_valid !== 1'b0) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL mid_stale got %0d exp 0", stale);
        end
        p         = mk_phv(72, 4'd3, 5'h1F);
        phv_in    = p;
        phv_valid = 1'b1;
        @(negedge clk);
        phv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b1 ||
            extract_key !== model_key(23'h0, p)) begin
            n_fail++;
            $display("FAIL mid_tbl_zero got %b/%h exp 1/%h",
                     key_valid, extract_key, model_key(23'h0, p));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flag_mask();
        test_back_to_back();
        test_backpressure();
        test_cfg_collision();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/key_extractor.md
KEY_EXTRACTOR -- requirements
Module: key_extractor

Interface
REQ-001 SHALL have parameter STAGE, default 0, pipeline stage index carried for configuration tagging.
REQ-002 SHALL have parameter PHV_LEN, default 1124, PHV width (8x48b + 8x32b + 8x16b + 5x20b + 256b metadata).
REQ-003 SHALL have parameter KEY_LEN, default 197, key width (2x48b + 2x32b + 2x16b + 5b flags).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port phv_in, input, PHV_LEN, parsed header vector from the upstream stage.
REQ-007 SHALL have port phv_valid, input, 1, phv_in valid this cycle.
REQ-008 SHALL have port phv_ready, output, 1, block accepts phv_in this cycle.
REQ-009 SHALL have port extract_key, output, KEY_LEN, key to the lookup engine.
REQ-010 SHALL have port key_valid, output, 1, extract_key and phv_out valid.
REQ-011 SHALL have port key_ready, input, 1, lookup engine accepts key this cycle.
REQ-012 SHALL have port phv_out, output, PHV_LEN, PHV aligned with extract_key.
REQ-013 SHALL have ports cfg_din (input, 23), cfg_addr (input, 4) and cfg_en (input, 1), the extraction-table write port.

Function
REQ-014 SHALL hold a 16-entry x 23b extraction table; entry = {idx48a[2:0], idx48b[2:0], idx32a[2:0], idx32b[2:0], idx16a[2:0], idx16b[2:0], flag_mask[4:0]}.
REQ-015 SHALL take PHV container fields MSB-first: 48b container i = phv[1123-48i -: 48]; 32b container i = phv[739-32i -: 32]; 16b container i = phv[483-16i -: 16]; table index vid = phv[255:252]; flags = phv[4:0].
REQ-016 SHALL form extract_key = {c48[idx48a], c48[idx48b], c32[idx32a], c32[idx32b], c16[idx16a], c16[idx16b], flags & flag_mask}.
REQ-017 SHALL be a 2-stage pipeline. S1 registers phv_in and table[vid] on a phv_valid && phv_ready handshake. S2 registers the muxed key and the PHV. Latency is 2 cycles from handshake to key_valid.
REQ-018 SHALL drive phv_ready = ~key_valid | key_ready (combinational) and stall globally: while key_valid && !key_ready, all S1/S2 registers hold and extract_key/phv_out stay stable.
REQ-019 SHALL complete a key transfer on key_valid && key_ready; key_valid deasserts next cycle unless S1 held a valid beat.
REQ-020 SHALL sustain 1 PHV/cycle when key_ready stays high; bubbles in phv_valid propagate as key_valid=0.
REQ-021 SHALL write table[cfg_addr] <= cfg_din when cfg_en=1, including during a stall.
REQ-022 SHALL give same-cycle write/read to the same entry the old data to S1; the new value applies from the next accepted PHV.
REQ-023 SHALL leave a beat already captured in S1 or S2 unaffected by later table writes.

Reset
REQ-024 SHALL, on rst=1, clear key_valid, extract_key, phv_out, S1 valid/data and all 16 table entries to 0, dropping in-flight beats.
REQ-025 SHALL drive phv_ready=1 in the cycle after rst deasserts.
REQ-026 SHALL ignore cfg_en while rst=1.

Structure
REQ-027 SHALL keep container offsets, counts/widths, VID and flag bit positions, and table entry field positions in a shared package, also used by lookup_engine.
REQ-028 SHALL place the 16x23 table in sub-module key_extract_cfg_ram (one write port, one registered-address read port). The container muxes and pipeline registers stay in key_extractor.

Verification
REQ-029 SHALL check basic extraction: table[3]={1,2,0,7,4,5,5'h1F}, PHV vid=3, c48[1]=48'hAAAA_0000_0001, c48[2]=48'hBBBB_0000_0002, flags=5'h15 -> 2 cycles later key_valid=1, key[196:149]=48'hAAAA00000001, key[148:101]=48'hBBBB00000002, key[4:0]=5'h15.
REQ-030 SHALL check the flag mask: same PHV, table[3] mask=5'h03 -> key[4:0]=5'h01.
REQ-031 SHALL check back-to-back throughput: 8 consecutive PHVs, key_ready=1 -> 8 consecutive key_valid cycles, keys in order, latency 2 each.
REQ-032 SHALL check backpressure: key_ready low for 3 cycles while 3 PHVs are issued -> phv_ready=0 during the stall, extract_key stable, no beat lost or duplicated after key_ready=1.
REQ-033 SHALL check config collision: cfg write table[5] in the same cycle as an accepted PHV with vid=5 -> that key uses the old entry; the next vid=5 PHV uses the new entry.
REQ-034 SHALL check reset mid-flight: rst=1 with 2 beats in flight -> key_valid=0 next cycle, table reads 0, no stale key emitted after reset.
